// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the ALU share arbiter.
//   - ALU ctrl and compare sub-op codes
//   - arbiter state type
//   - op_legal(): true when a ctrl/comp pair may be issued to the ALU
package alu_arb_pkg;

  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlComp = 4'b0111;
  localparam logic [3:0] CtrlNor  = 4'b1100;
  localparam logic [3:0] CtrlNand = 4'b1101;

  localparam logic [2:0] CompSlt  = 3'b000;
  localparam logic [2:0] CompSgt  = 3'b001;
  localparam logic [2:0] CompSle  = 3'b010;
  localparam logic [2:0] CompSge  = 3'b011;
  localparam logic [2:0] CompSne  = 3'b100;
  localparam logic [2:0] CompSltu = 3'b101;
  localparam logic [2:0] CompSeq  = 3'b110;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  function automatic logic op_legal(input logic [3:0] ctrl, input logic [2:0] comp);
    logic legal;
    case (ctrl)
      CtrlAnd, CtrlOr, CtrlAdd, CtrlSub, CtrlNor, CtrlNand: legal = 1'b1;
      CtrlComp: legal = comp inside {CompSlt, CompSgt, CompSle, CompSge,
                                     CompSne, CompSltu, CompSeq};
      default:  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational 2-way round-robin picker.
// Ports:
//   valid_i      : request valids, bit N = requester N
//   last_grant_i : requester granted most recently
//   grant_o      : one-hot grant (all zero when nothing is valid)
//   grant_id_o   : index of the granted requester
module alu_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  always_comb begin
    grant_id_o = 1'b0;
    case (valid_i)
      2'b11:   grant_id_o = ~last_grant_i;  // tie: the one not served last
      2'b10:   grant_id_o = 1'b1;
      default: grant_id_o = 1'b0;
    endcase
    grant_o = valid_i & (grant_id_o ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two requesters.
// One operation is in flight at a time: IDLE (arbitrate) -> EXEC (drive ALU) -> RESP.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   req{0,1}_*       : request channels (valid/ready, src1, src2, ctrl, comp)
//   rsp{0,1}_*       : response channels, held until rsp ready
//   alu_*_o / alu_*_i: operands/opcode to the shared ALU, result and flags back
//   ops_done_o       : responses accepted since reset, wraps
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_src1_i,
  input  logic [DATA_W-1:0] req0_src2_i,
  input  logic [3:0]        req0_ctrl_i,
  input  logic [2:0]        req0_comp_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_src1_i,
  input  logic [DATA_W-1:0] req1_src2_i,
  input  logic [3:0]        req1_ctrl_i,
  input  logic [2:0]        req1_comp_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_result_o,
  output logic [2:0]        rsp0_flags_o,
  output logic              rsp0_err_o,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_result_o,
  output logic [2:0]        rsp1_flags_o,
  output logic              rsp1_err_o,
  output logic              alu_rst_n_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  output logic [2:0]        alu_comp_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  input  logic              alu_cout_i,
  input  logic              alu_overflow_i,
  output logic [CNT_W-1:0]  ops_done_o
);

  arb_state_e        r_state;
  logic              r_last_grant;
  logic              r_id;
  logic              r_err;
  logic              r_alu_rst_n;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_ctrl;
  logic [2:0]        r_comp;
  logic [2:0]        r_flags;
  logic [CNT_W-1:0]  r_ops_done;

  logic [1:0]        w_grant;
  logic              w_grant_id;
  logic              w_handshake;
  logic              w_legal;
  logic              w_rsp_accept;
  logic              w_exec;
  logic [DATA_W-1:0] w_src1;
  logic [DATA_W-1:0] w_src2;
  logic [3:0]        w_ctrl;
  logic [2:0]        w_comp;

  alu_rr_pick u_pick (
    .valid_i      ({req1_valid_i, req0_valid_i}),
    .last_grant_i (r_last_grant),
    .grant_o      (w_grant),
    .grant_id_o   (w_grant_id)
  );

  // Payload of the granted requester.
  assign w_src1 = w_grant_id ? req1_src1_i : req0_src1_i;
  assign w_src2 = w_grant_id ? req1_src2_i : req0_src2_i;
  assign w_ctrl = w_grant_id ? req1_ctrl_i : req0_ctrl_i;
  assign w_comp = w_grant_id ? req1_comp_i : req0_comp_i;
  assign w_legal = op_legal(w_ctrl, w_comp);

  assign req0_ready_o = (r_state == StIdle) && w_grant[0];
  assign req1_ready_o = (r_state == StIdle) && w_grant[1];
  assign w_handshake  = (r_state == StIdle) && (req0_valid_i || req1_valid_i);
  assign w_rsp_accept = (r_state == StResp) && (r_id ? rsp1_ready_i : rsp0_ready_i);

  assign rsp0_valid_o  = (r_state == StResp) && !r_id;
  assign rsp1_valid_o  = (r_state == StResp) && r_id;
  assign rsp0_result_o = r_result;
  assign rsp1_result_o = r_result;
  assign rsp0_flags_o  = r_flags;
  assign rsp1_flags_o  = r_flags;
  assign rsp0_err_o    = r_err;
  assign rsp1_err_o    = r_err;

  // The ALU only sees the operation during EXEC; otherwise it is held at zero.
  assign w_exec      = (r_state == StExec);
  assign alu_src1_o  = w_exec ? r_src1 : '0;
  assign alu_src2_o  = w_exec ? r_src2 : '0;
  assign alu_ctrl_o  = w_exec ? r_ctrl : '0;
  assign alu_comp_o  = w_exec ? r_comp : '0;
  assign alu_rst_n_o = r_alu_rst_n;
  assign ops_done_o  = r_ops_done;

  always_ff @(posedge clk_i) begin
    r_alu_rst_n <= ~rst_i;
    if (rst_i) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_ctrl       <= '0;
      r_comp       <= '0;
      r_result     <= '0;
      r_flags      <= '0;
      r_err        <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_handshake) begin
            r_src1       <= w_src1;
            r_src2       <= w_src2;
            r_ctrl       <= w_ctrl;
            r_comp       <= w_comp;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            if (w_legal) begin
              r_state <= StExec;
            end else begin
              // Illegal ops never reach the ALU; answer immediately with an error.
              r_result <= '0;
              r_flags  <= '0;
              r_err    <= 1'b1;
              r_state  <= StResp;
            end
          end
        end
        StExec: begin
          r_result <= alu_result_i;
          r_flags  <= {alu_overflow_i, alu_cout_i, alu_zero_i};
          r_err    <= 1'b0;
          r_state  <= StResp;
        end
        StResp: begin
          if (w_rsp_accept) begin
            r_state    <= StIdle;
            r_ops_done <= r_ops_done + CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
